rf_wb_sequencer: RTL and testbench

//   Write-back front end for the 32x8 register file; sits directly upstream of its CLK/DIN/RF_WR/ADRX inputs.

---
 rtl/rf_wb_sequencer.sv | 132 +++++++++++++
 tb/tb_rf_wb_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rf_wb_sequencer
// Function : Register-file write-back front end. It clears every register to
//            INIT_VAL after reset or on request, and otherwise passes CPU writes through.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rf_wb_sequencer #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 5,
   parameter int                DEPTH    = 32,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CLR_REQ,
   input  logic              RF_WR_IN,
   input  logic [ADDR_W-1:0] ADRX_IN,
   input  logic [1:0]        RF_WR_SEL,
   input  logic [DATA_W-1:0] ALU_RESULT,
   input  logic [DATA_W-1:0] SCR_DATA,
   input  logic [DATA_W-1:0] IN_PORT,
   input  logic [DATA_W-1:0] IMM,
   output logic              BUSY,
   output logic              DONE,
   output logic              RF_WR,
   output logic [ADDR_W-1:0] ADRX,
   output logic [DATA_W-1:0] DIN
);

   localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_done;
   logic              r_busy;

   logic [DATA_W-1:0] w_sel_data;
   logic              w_rf_wr;
   logic [ADDR_W-1:0] w_adrx;
   logic [DATA_W-1:0] w_din;

   // BUSY is kept as its own flop so it is glitch-free toward the CPU stall logic.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_START;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_START: begin
               r_state <= ST_CLEAR;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
            end
            ST_CLEAR: begin
               if (r_cnt == c_last) begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + c_one;
               end
            end
            ST_RUN: begin
               if (CLR_REQ) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_START;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      w_sel_data = ALU_RESULT;
      case (RF_WR_SEL)
         2'd0:    w_sel_data = ALU_RESULT;
         2'd1:    w_sel_data = SCR_DATA;
         2'd2:    w_sel_data = IN_PORT;
         default: w_sel_data = IMM;
      endcase
   end

   // The RUN path stays combinational so CPU writes see no added latency.
   always_comb begin
      w_rf_wr = 1'b0;
      w_adrx  = '0;
      w_din   = '0;
      case (r_state)
         ST_CLEAR: begin
            w_rf_wr = 1'b1;
            w_adrx  = r_cnt;
            w_din   = INIT_VAL;
         end
         ST_RUN: begin
            w_rf_wr = RF_WR_IN;
            w_adrx  = ADRX_IN;
            w_din   = w_sel_data;
         end
         default: begin
            w_rf_wr = 1'b0;
            w_adrx  = '0;
            w_din   = '0;
         end
      endcase
   end

   assign BUSY  = r_busy;
   assign DONE  = r_done;
   assign RF_WR = w_rf_wr;
   assign ADRX  = w_adrx;
   assign DIN   = w_din;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_rf_wb_sequencer
// Function : Scoreboard bench for rf_wb_sequencer (default and DEPTH=8 instances).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rf_wb_sequencer;

   typedef struct packed {
      logic       s8;
      logic       busy;
      logic       done;
      logic       wr;
      logic [4:0] adrx;
      logic [7:0] din;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       RST8_N = 1'b0;
   logic       CLR_REQ = 1'b0;
   logic       RF_WR_IN = 1'b0;
   logic [4:0] ADRX_IN = '0;
   logic [1:0] RF_WR_SEL = '0;
   logic [7:0] ALU_RESULT = '0;
   logic [7:0] SCR_DATA = '0;
   logic [7:0] IN_PORT = '0;
   logic [7:0] IMM = '0;

   logic       BUSY, DONE, RF_WR;
   logic [4:0] ADRX;
   logic [7:0] DIN;
   logic       BUSY8, DONE8, RF_WR8;
   logic [4:0] ADRX8;
   logic [7:0] DIN8;

   int    errors = 0;
   int    checks = 0;
   exp_t  q[$];
   string tag = "reset";

   logic [7:0] rf  [32];
   logic [7:0] rf8 [32];
   bit         seeded;

   always #5 CLK = ~CLK;

   rf_wb_sequencer dut (
      .CLK(CLK), .RST_N(RST_N), .CLR_REQ(CLR_REQ), .RF_WR_IN(RF_WR_IN),
      .ADRX_IN(ADRX_IN), .RF_WR_SEL(RF_WR_SEL), .ALU_RESULT(ALU_RESULT),
      .SCR_DATA(SCR_DATA), .IN_PORT(IN_PORT), .IMM(IMM),
      .BUSY(BUSY), .DONE(DONE), .RF_WR(RF_WR), .ADRX(ADRX), .DIN(DIN)
   );

   rf_wb_sequencer #(.DEPTH(8), .INIT_VAL(8'hFF)) dut8 (
      .CLK(CLK), .RST_N(RST8_N), .CLR_REQ(CLR_REQ), .RF_WR_IN(RF_WR_IN),
      .ADRX_IN(ADRX_IN), .RF_WR_SEL(RF_WR_SEL), .ALU_RESULT(ALU_RESULT),
      .SCR_DATA(SCR_DATA), .IN_PORT(IN_PORT), .IMM(IMM),
      .BUSY(BUSY8), .DONE(DONE8), .RF_WR(RF_WR8), .ADRX(ADRX8), .DIN(DIN8)
   );

   // Register-file models fed by the DUT write ports.
   always @(posedge CLK) begin
      if (RF_WR) rf[ADRX] <= DIN;
   end

   always @(posedge CLK) begin
      if (!seeded) begin
         for (int i = 0; i < 32; i++) rf8[i] <= 8'h5A;
         seeded <= 1'b1;
      end else if (RF_WR8) begin
         rf8[ADRX8] <= DIN8;
      end
   end

   // Monitor: one expected entry per cycle, sampled mid-cycle.
   always @(negedge CLK) begin
      exp_t e, act;
      if (q.size() != 0) begin
         e   = q.pop_front();
         act = e.s8 ? {1'b1, BUSY8, DONE8, RF_WR8, ADRX8, DIN8}
                    : {1'b0, BUSY, DONE, RF_WR, ADRX, DIN};
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s t=%0t got busy=%b done=%b wr=%b adrx=%0d din=%h exp busy=%b done=%b wr=%b adrx=%0d din=%h",
                     tag, $time, act.busy, act.done, act.wr, act.adrx, act.din,
                     e.busy, e.done, e.wr, e.adrx, e.din);
         end
      end
   end

   task automatic cyc(input logic s8, input logic b, input logic d, input logic w,
                      input logic [4:0] a, input logic [7:0] v);
      q.push_back('{s8: s8, busy: b, done: d, wr: w, adrx: a, din: v});
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_rf(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, act, exp_v);
      end
   endtask

   initial begin
      @(posedge CLK);
      #1;
      // Reset held: CPU inputs active but must be ignored.
      RF_WR_IN = 1'b1; ADRX_IN = 5'd9; ALU_RESULT = 8'h3C;
      cyc(0, 1, 0, 0, 5'd0, 8'h00);
      cyc(0, 1, 0, 0, 5'd0, 8'h00);

      tag = "power_up_clear";
      RST_N = 1'b1;
      cyc(0, 1, 0, 0, 5'd0, 8'h00);
      for (int i = 0; i < 32; i++) cyc(0, 1, 0, 1, 5'(i), 8'h00);
      RF_WR_IN = 1'b0; ADRX_IN = 5'd0; ALU_RESULT = 8'h00;
      cyc(0, 0, 1, 0, 5'd0, 8'h00);
      cyc(0, 0, 0, 0, 5'd0, 8'h00);

      tag = "din_mux";
      ALU_RESULT = 8'h3C; SCR_DATA = 8'hA5; IN_PORT = 8'h7E; IMM = 8'h11;
      RF_WR_IN = 1'b1; ADRX_IN = 5'd5;
      RF_WR_SEL = 2'd0; cyc(0, 0, 0, 1, 5'd5, 8'h3C);
      RF_WR_SEL = 2'd1; cyc(0, 0, 0, 1, 5'd5, 8'hA5);
      RF_WR_SEL = 2'd2; cyc(0, 0, 0, 1, 5'd5, 8'h7E);
      RF_WR_SEL = 2'd3; cyc(0, 0, 0, 1, 5'd5, 8'h11);
      RF_WR_IN = 1'b0; RF_WR_SEL = 2'd0;
      cyc(0, 0, 0, 0, 5'd5, 8'h3C);

      tag = "write_with_clr";
      ADRX_IN = 5'd7; RF_WR_SEL = 2'd3; IMM = 8'h99; RF_WR_IN = 1'b1; CLR_REQ = 1'b1;
      cyc(0, 0, 0, 1, 5'd7, 8'h99);
      chk_rf("r7_written", rf[7], 8'h99);
      CLR_REQ = 1'b0; RF_WR_IN = 1'b0;
      for (int i = 0; i < 32; i++) cyc(0, 1, 0, 1, 5'(i), 8'h00);
      cyc(0, 0, 1, 0, 5'd7, 8'h99);
      chk_rf("r7_cleared", rf[7], 8'h00);

      tag = "reset_mid_clear";
      CLR_REQ = 1'b1;
      cyc(0, 0, 0, 0, 5'd7, 8'h99);
      CLR_REQ = 1'b0;
      for (int i = 0; i < 16; i++) cyc(0, 1, 0, 1, 5'(i), 8'h00);
      RST_N = 1'b0;
      cyc(0, 1, 0, 0, 5'd0, 8'h00);
      cyc(0, 1, 0, 0, 5'd0, 8'h00);
      RST_N = 1'b1;
      cyc(0, 1, 0, 0, 5'd0, 8'h00);
      for (int i = 0; i < 32; i++) cyc(0, 1, 0, 1, 5'(i), 8'h00);
      cyc(0, 0, 1, 0, 5'd7, 8'h99);

      tag = "clr_during_clear";
      ADRX_IN = 5'd3; IMM = 8'h55; RF_WR_IN = 1'b1;
      cyc(0, 0, 0, 1, 5'd3, 8'h55);
      chk_rf("r3_written", rf[3], 8'h55);
      RF_WR_IN = 1'b0; CLR_REQ = 1'b1;
      cyc(0, 0, 0, 0, 5'd3, 8'h55);
      for (int i = 0; i < 32; i++) begin
         if (i == 10) begin
            CLR_REQ = 1'b1; RF_WR_IN = 1'b1; IMM = 8'h77;
         end else begin
            CLR_REQ = 1'b0; RF_WR_IN = 1'b0;
         end
         cyc(0, 1, 0, 1, 5'(i), 8'h00);
      end
      CLR_REQ = 1'b0; RF_WR_IN = 1'b0;
      cyc(0, 0, 1, 0, 5'd3, 8'h77);
      cyc(0, 0, 0, 0, 5'd3, 8'h77);
      chk_rf("r3_after_clear", rf[3], 8'h00);

      tag = "depth8_ff";
      ADRX_IN = 5'd0; RF_WR_SEL = 2'd0; ALU_RESULT = 8'h3C;
      RST8_N = 1'b1;
      cyc(1, 1, 0, 0, 5'd0, 8'h00);
      for (int i = 0; i < 8; i++) cyc(1, 1, 0, 1, 5'(i), 8'hFF);
      cyc(1, 0, 1, 0, 5'd0, 8'h3C);
      cyc(1, 0, 0, 0, 5'd0, 8'h3C);
      for (int i = 0; i < 8; i++)  chk_rf($sformatf("d8_r%0d", i), rf8[i], 8'hFF);
      for (int i = 8; i < 32; i++) chk_rf($sformatf("d8_r%0d", i), rf8[i], 8'h5A);

      repeat (3) @(posedge CLK);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
